// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2
    } fetch_state_e;

    localparam int                 INSTR_W   = 32;
    localparam logic [31:0]        PC_INC    = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Redirect targets are byte addresses; fetch only ever issues word-aligned reads.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/pc_reg_en.sv
// Loadable register with asynchronous active-high reset to a parameter value.
module pc_reg_en #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] val_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= RST_VAL;
        end else if (en_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, reads instruction memory over req/ack,
// and hands instructions to decode through a valid/ready output register.
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc4,
    input  logic               if_ready
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, pend_pc_q, redir_pc;
    logic         pc_en, pend_en, out_en;
    logic         drop_q, drop_d;
    logic         valid_q, valid_d;
    logic         req_q;

    assign redir_pc = word_align(redirect_pc);

    // State register; imem_req is registered from the next state so it is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_START;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ST_FETCH);
            drop_q  <= drop_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_START:   state_d = ST_FETCH;
            ST_FETCH:   if (imem_ack && !drop_q && !redirect) state_d = ST_DELIVER;
            ST_DELIVER: if (redirect || if_ready) state_d = ST_FETCH;
            default:    state_d = ST_START;
        endcase
    end

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        pc_en   = 1'b0;
        pc_d    = pc_q;
        pend_en = 1'b0;
        out_en  = 1'b0;
        drop_d  = drop_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_START: begin
                if (redirect) begin
                    pc_en = 1'b1;
                    pc_d  = redir_pc;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    pc_en = 1'b1;
                    if (drop_q || redirect) begin
                        // Squashed response: restart at the newest target.
                        pc_d   = redirect ? redir_pc : pend_pc_q;
                        drop_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + PC_INC;
                        out_en  = 1'b1;
                        valid_d = 1'b1;
                    end
                end else if (redirect) begin
                    pend_en = 1'b1;
                    drop_d  = 1'b1;
                end
            end
            ST_DELIVER: begin
                if (redirect) begin
                    pc_en   = 1'b1;
                    pc_d    = redir_pc;
                    valid_d = 1'b0;
                end else if (if_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    pc_reg_en #(.W(32), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
    );

    pc_reg_en #(.W(32), .RST_VAL(32'h0)) u_pend_pc (
        .clk(clk), .rst(rst), .en_i(pend_en), .d_i(redir_pc), .q_o(pend_pc_q)
    );

    pc_reg_en #(.W(INSTR_W), .RST_VAL(NOP_INSTR)) u_if_instr (
        .clk(clk), .rst(rst), .en_i(out_en), .d_i(imem_rdata), .q_o(if_instr)
    );

    pc_reg_en #(.W(32), .RST_VAL(32'h0)) u_if_pc (
        .clk(clk), .rst(rst), .en_i(out_en), .d_i(pc_q), .q_o(if_pc)
    );

    pc_reg_en #(.W(32), .RST_VAL(32'h0)) u_if_pc4 (
        .clk(clk), .rst(rst), .en_i(out_en), .d_i(pc_q + PC_INC), .q_o(if_pc4)
    );

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed timing scenarios plus a randomized
// run checked against a transaction-level model of the expected instruction stream.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req, imem_ack, redirect, if_valid, if_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, if_pc4;

    logic        rst_b, req_b, ack_b, redirect_b, valid_b, ready_b;
    logic [31:0] addr_b, rdata_b, rpc_b, instr_b, pc_b, pc4_b;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc4(if_pc4), .if_ready(if_ready)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(ack_b), .imem_rdata(rdata_b), .redirect(redirect_b),
        .redirect_pc(rpc_b), .if_valid(valid_b), .if_instr(instr_b),
        .if_pc(pc_b), .if_pc4(pc4_b), .if_ready(ready_b)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          wait_cycles = 0;
    int          outstanding = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
        outstanding = (prev_req && !prev_ack) ? outstanding + 1 : 0;
    endtask

    // Memory model: acks a request after wait_cycles cycles of it being outstanding.
    task automatic drive_mem();
        imem_ack   = imem_req && (outstanding >= wait_cycles);
        imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; wait_cycles = 0;
        tick();
        tick();
        rst = 1'b0;
        outstanding = 0;
        drive_mem();
    endtask

    task automatic test_reset_pc();
        ready_b = 1'b1; ack_b = 1'b0; rdata_b = 32'h0;
        tick();
        n_tests++;
        if ({req_b, addr_b, valid_b} !== {1'b0, 32'hFFFF_FFFC, 1'b0}) begin
            n_fail++; $display("FAIL rp_reset: got %h, expected %h", {req_b, addr_b, valid_b}, {1'b0, 32'hFFFF_FFFC, 1'b0});
        end
        rst_b = 1'b0;
        tick();
        n_tests++;
        if ({req_b, addr_b} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_fail++; $display("FAIL rp_first_req: got %h, expected %h", {req_b, addr_b}, {1'b1, 32'hFFFF_FFFC});
        end
        ack_b = 1'b1; rdata_b = mem_word(addr_b);
        tick();
        ack_b = 1'b0;
        n_tests++;
        if ({valid_b, pc_b, instr_b, pc4_b} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0}) begin
            n_fail++; $display("FAIL rp_wrap_deliver: got %h, expected %h", {valid_b, pc_b, instr_b, pc4_b}, {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0});
        end
        tick();
        n_tests++;
        if ({req_b, addr_b} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL rp_second_fetch: got %h, expected %h", {req_b, addr_b}, {1'b1, 32'h0});
        end
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4} !== {1'b0, 32'h0, 1'b0, 96'h0}) begin
            n_fail++; $display("FAIL reset_values: got %h, expected 0", {imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4});
        end
        do_reset();
        n_tests++;
        if (imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_start_idle: got req=%b, expected 0", imem_req);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pc = 32'(4 * k);
            tick();
            n_tests++;
            if ({imem_req, imem_addr, if_valid} !== {1'b1, pc, 1'b0}) begin
                n_fail++; $display("FAIL zw_req k=%0d: got %h, expected %h", k, {imem_req, imem_addr, if_valid}, {1'b1, pc, 1'b0});
            end
            drive_mem();
            tick();
            n_tests++;
            if ({imem_req, if_valid, if_pc, if_instr, if_pc4} !== {1'b0, 1'b1, pc, mem_word(pc), pc + 32'd4}) begin
                n_fail++; $display("FAIL zw_deliver k=%0d: got %h, expected %h", k, {imem_req, if_valid, if_pc, if_instr, if_pc4}, {1'b0, 1'b1, pc, mem_word(pc), pc + 32'd4});
            end
            drive_mem();
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        wait_cycles = 3;
        drive_mem();
        tick();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL ws_req_rise: got %h, expected %h", {imem_req, imem_addr}, {1'b1, 32'h0});
        end
        for (int i = 0; i < 3; i++) begin
            drive_mem();
            tick();
            n_tests++;
            if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
                n_fail++; $display("FAIL ws_hold i=%0d: got %h, expected %h", i, {imem_req, imem_addr, if_valid}, {1'b1, 32'h0, 1'b0});
            end
        end
        drive_mem();
        tick();
        n_tests++;
        if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h0, mem_word(32'h0)}) begin
            n_fail++; $display("FAIL ws_deliver: got %h, expected %h", {imem_req, if_valid, if_pc, if_instr}, {1'b0, 1'b1, 32'h0, mem_word(32'h0)});
        end
    endtask

    task automatic test_stall();
        do_reset();
        if_ready = 1'b0;
        tick();
        drive_mem();
        tick();
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h0, mem_word(32'h0)}) begin
                n_fail++; $display("FAIL st_hold i=%0d: got %h, expected %h", i, {imem_req, if_valid, if_pc, if_instr}, {1'b0, 1'b1, 32'h0, mem_word(32'h0)});
            end
            if (i < 5) begin
                drive_mem();
                tick();
            end
        end
        if_ready = 1'b1;
        drive_mem();
        tick();
        n_tests++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h4, 1'b0}) begin
            n_fail++; $display("FAIL st_resume: got %h, expected %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h4, 1'b0});
        end
    endtask

    task automatic test_redirect_wait();
        logic seen;
        do_reset();
        wait_cycles = 3;
        redirect = 1'b1; redirect_pc = 32'h10;
        drive_mem();
        tick();
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL rw_start_redirect: got %h, expected %h", {imem_req, imem_addr}, {1'b1, 32'h10});
        end
        redirect_pc = 32'h400;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) redirect_pc = 32'h800;
            if (i >= 2) redirect = 1'b0;
            drive_mem();
            tick();
            if (i < 3) begin
                n_tests++;
                if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h10, 1'b0}) begin
                    n_fail++; $display("FAIL rw_hold i=%0d: got %h, expected %h", i, {imem_req, imem_addr, if_valid}, {1'b1, 32'h10, 1'b0});
                end
            end
        end
        n_tests++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h800, 1'b0}) begin
            n_fail++; $display("FAIL rw_new_addr: got %h, expected %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h800, 1'b0});
        end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            drive_mem();
            tick();
            if (if_valid) seen = 1'b1;
        end
        n_tests++;
        if (!seen || {if_pc, if_instr} !== {32'h800, mem_word(32'h800)}) begin
            n_fail++; $display("FAIL rw_first_valid: seen=%b got %h, expected %h", seen, {if_pc, if_instr}, {32'h800, mem_word(32'h800)});
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0403;
        drive_mem();
        tick();
        redirect = 1'b0;
        n_tests++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h400, 1'b0}) begin
            n_fail++; $display("FAIL ra_drop: got %h, expected %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h400, 1'b0});
        end
        drive_mem();
        tick();
        n_tests++;
        if ({if_valid, if_pc, if_instr, if_pc4} !== {1'b1, 32'h400, mem_word(32'h400), 32'h404}) begin
            n_fail++; $display("FAIL ra_deliver: got %h, expected %h", {if_valid, if_pc, if_instr, if_pc4}, {1'b1, 32'h400, mem_word(32'h400), 32'h404});
        end
        redirect = 1'b1; redirect_pc = 32'h0000_1003; if_ready = 1'b1;
        drive_mem();
        tick();
        redirect = 1'b0;
        n_tests++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h1000, 1'b0}) begin
            n_fail++; $display("FAIL ra_deliver_redirect: got %h, expected %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h1000, 1'b0});
        end
        drive_mem();
        tick();
        n_tests++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h1000, mem_word(32'h1000)}) begin
            n_fail++; $display("FAIL ra_after_redirect: got %h, expected %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h1000, mem_word(32'h1000)});
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        wait_cycles = 3;
        drive_mem();
        tick();
        drive_mem();
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({imem_req, imem_addr, if_valid} !== {1'b0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL mr_async: got %h, expected %h", {imem_req, imem_addr, if_valid}, {1'b0, 32'h0, 1'b0});
        end
        tick();
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        n_tests++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL mr_restart: got %h, expected %h", {imem_req, imem_addr, if_valid}, {1'b1, 32'h0, 1'b0});
        end
        wait_cycles = 0;
        drive_mem();
        tick();
        n_tests++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            n_fail++; $display("FAIL mr_deliver: got %h, expected %h", {if_valid, if_pc, if_instr}, {1'b1, 32'h0, mem_word(32'h0)});
        end
    endtask

    // Model: the stream decode sees is sequential from the last redirect target,
    // advancing only on an accepted handshake.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          delivered;
        do_reset();
        exp_pc    = 32'h0;
        delivered = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (if_valid) begin
                n_tests++;
                if ({if_pc, if_instr, if_pc4} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin
                    n_fail++; $display("FAIL rnd_data c=%0d: got %h, expected %h", c, {if_pc, if_instr, if_pc4}, {exp_pc, mem_word(exp_pc), exp_pc + 32'd4});
                end
            end
            if (prev_req && !prev_ack) begin
                n_tests++;
                if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
                    n_fail++; $display("FAIL rnd_req_stable c=%0d: got %h, expected %h", c, {imem_req, imem_addr}, {1'b1, prev_addr});
                end
            end
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom();
            if_ready    = ($urandom_range(0, 3) != 0);
            if (redirect) begin
                exp_pc = redirect_pc & ~32'h3;
            end else if (if_valid && if_ready) begin
                exp_pc    = exp_pc + 32'd4;
                delivered = delivered + 1;
            end
            if (outstanding == 0) wait_cycles = $urandom_range(0, 3);
            drive_mem();
        end
        redirect = 1'b0;
        n_tests++;
        if (delivered < 20) begin
            n_fail++; $display("FAIL rnd_progress: got %0d delivered, expected at least 20", delivered);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect_b = 1'b0; rpc_b = 32'h0; ready_b = 1'b1; ack_b = 1'b0; rdata_b = 32'h0;
        test_reset_pc();
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
